// File: rtl/cpu_pkg.sv
// Shared CPU constants for the write-back path.
//   WBSEL_* : write-back source select encodings (11 is reserved and behaves as ALU)
//   LD_*    : load type encodings (unlisted codes behave as LW)
package cpu_pkg;
    localparam logic [1:0] WBSEL_ALU  = 2'b00;
    localparam logic [1:0] WBSEL_LOAD = 2'b01;
    localparam logic [1:0] WBSEL_PC4  = 2'b10;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LH  = 3'd1;
    localparam logic [2:0] LD_LHU = 3'd2;
    localparam logic [2:0] LD_LB  = 3'd3;
    localparam logic [2:0] LD_LBU = 3'd4;
endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB stage bundle.
//   master : MEM stage / pipeline control side, drives everything
//   slave  : write-back stage, samples everything
// Signals: mem_valid, mem_regwr, mem_rd, mem_wbsel, mem_alu_res, mem_pc4,
//          mem_rdata, mem_ldtype, wb_stall, wb_flush.
interface mem_wb_stage_if
    import cpu_pkg::*;
#(
    parameter int DW = 32
);
    logic          mem_valid;
    logic          mem_regwr;
    logic [4:0]    mem_rd;
    logic [1:0]    mem_wbsel;
    logic [DW-1:0] mem_alu_res;
    logic [DW-1:0] mem_pc4;
    logic [DW-1:0] mem_rdata;
    logic [2:0]    mem_ldtype;
    logic          wb_stall;
    logic          wb_flush;

    modport master (
        output mem_valid, mem_regwr, mem_rd, mem_wbsel, mem_alu_res,
               mem_pc4, mem_rdata, mem_ldtype, wb_stall, wb_flush
    );

    modport slave (
        input  mem_valid, mem_regwr, mem_rd, mem_wbsel, mem_alu_res,
               mem_pc4, mem_rdata, mem_ldtype, wb_stall, wb_flush
    );
endinterface

// File: rtl/mem_wb_stage_load_align.sv
// Combinational load alignment: picks the addressed byte/half out of the raw
// little-endian memory word, sign- or zero-extends it, and flags misaligned
// accesses.
//   rdata      : raw aligned word from data memory
//   addr       : low two bits of the effective address
//   ldtype     : load type (cpu_pkg LD_*)
//   data       : extended load value
//   misaligned : LW with addr != 0, or LH/LHU with addr[0] set
module load_align
    import cpu_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] rdata,
    input  logic [1:0]    addr,
    input  logic [2:0]    ldtype,
    output logic [DW-1:0] data,
    output logic          misaligned
);
    logic signed [7:0]  byte_sel;
    logic signed [15:0] half_sel;

    function automatic logic [DW-1:0] sext8(input logic signed [7:0] b);
        return {{(DW-8){b[7]}}, b};
    endfunction

    function automatic logic [DW-1:0] zext8(input logic signed [7:0] b);
        return {{(DW-8){1'b0}}, b};
    endfunction

    function automatic logic [DW-1:0] sext16(input logic signed [15:0] h);
        return {{(DW-16){h[15]}}, h};
    endfunction

    function automatic logic [DW-1:0] zext16(input logic signed [15:0] h);
        return {{(DW-16){1'b0}}, h};
    endfunction

    always_comb begin
        case (addr)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (ldtype)
            LD_LH: begin
                data       = sext16(half_sel);
                misaligned = addr[0];
            end
            LD_LHU: begin
                data       = zext16(half_sel);
                misaligned = addr[0];
            end
            LD_LB:  data = sext8(byte_sel);
            LD_LBU: data = zext8(byte_sel);
            default: begin
                data       = rdata;
                misaligned = |addr;
            end
        endcase
    end
endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back stage.
//   clk, rst     : clock and synchronous active-low reset
//   mem          : MEM-stage instruction plus wb_stall / wb_flush (slave side)
//   RFWr/A3/WD   : register-file write port, asserted once per entry
//   fwd_*        : forwarding tap, valid for as long as the entry is held
//   exc_misalign : one-cycle pulse when a misaligned load is dropped
//   retire_cnt   : retired-instruction counter, wraps modulo 2^CNT_W
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_wb_stage_if.slave     mem,
    output logic              RFWr,
    output logic [4:0]        A3,
    output logic [DW-1:0]     WD,
    output logic              fwd_valid,
    output logic [4:0]        fwd_rd,
    output logic [DW-1:0]     fwd_data,
    output logic              exc_misalign,
    output logic [CNT_W-1:0]  retire_cnt
);
    logic [DW-1:0] ld_data;
    logic          ld_mis;
    logic [DW-1:0] wd_in;
    logic          mis_in;

    logic          v_p1;
    logic          wr_p1;
    logic [4:0]    rd_p1;
    logic [DW-1:0] wd_p1;
    logic          mis_p1;
    logic          done_p1;

    load_align #(.DW(DW)) u_load_align (
        .rdata      (mem.mem_rdata),
        .addr       (mem.mem_alu_res[1:0]),
        .ldtype     (mem.mem_ldtype),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    // Alignment only matters for instructions that actually take load data.
    always_comb begin
        mis_in = (mem.mem_wbsel == WBSEL_LOAD) && ld_mis;
        case (mem.mem_wbsel)
            WBSEL_LOAD: wd_in = ld_data;
            WBSEL_PC4:  wd_in = mem.mem_pc4;
            default:    wd_in = mem.mem_alu_res;
        endcase
    end

    // ---- MEM / WB stage boundary ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            v_p1    <= 1'b0;
            wr_p1   <= 1'b0;
            rd_p1   <= '0;
            wd_p1   <= '0;
            mis_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else if (mem.wb_flush) begin
            v_p1    <= 1'b0;
            wr_p1   <= 1'b0;
            mis_p1  <= 1'b0;
            done_p1 <= 1'b0;
        end else if (mem.wb_stall) begin
            // A held entry has been presented once; block further writes.
            done_p1 <= v_p1;
        end else begin
            v_p1    <= mem.mem_valid;
            wr_p1   <= mem.mem_regwr && (mem.mem_rd != 5'd0) && !mis_in;
            rd_p1   <= mem.mem_rd;
            wd_p1   <= wd_in;
            mis_p1  <= mis_in;
            done_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            retire_cnt <= '0;
        else if (v_p1 && !done_p1)
            retire_cnt <= retire_cnt + CNT_W'(1);
    end

    assign RFWr         = v_p1 && wr_p1 && !done_p1;
    assign A3           = rd_p1;
    assign WD           = wd_p1;
    assign fwd_valid    = v_p1 && wr_p1;
    assign fwd_rd       = rd_p1;
    assign fwd_data     = wd_p1;
    assign exc_misalign = v_p1 && mis_p1 && !done_p1;
endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam int DW    = 32;
    localparam int CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_wb_stage_if #(.DW(DW)) mif ();

    logic              RFWr;
    logic [4:0]        A3;
    logic [DW-1:0]     WD;
    logic              fwd_valid;
    logic [4:0]        fwd_rd;
    logic [DW-1:0]     fwd_data;
    logic              exc_misalign;
    logic [CNT_W-1:0]  retire_cnt;

    mem_wb_stage #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .mem          (mif),
        .RFWr         (RFWr),
        .A3           (A3),
        .WD           (WD),
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
        .exc_misalign (exc_misalign),
        .retire_cnt   (retire_cnt)
    );

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;

    int          total = 0;
    int          bad   = 0;
    wr_t         wq[$];
    int          mq[$];
    int          exp_cnt = 0;
    bit          cur_v = 0;
    logic [4:0]  cur_rd = '0;
    logic [31:0] cur_wd = '0;
    bit          mon_en = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference: value = whatever the instruction asks for, with loads
    // computed by shifting the addressed byte/half down and extending.
    function automatic void ref_model(input logic [1:0] wbsel, input logic [31:0] alu,
                                      input logic [31:0] pc4, input logic [31:0] rdata,
                                      input logic [2:0] ldt,
                                      output logic [31:0] wd, output bit mis);
        int unsigned k, h;
        logic [31:0] b, hw;
        k   = alu % 4;
        h   = (alu % 4) / 2;
        b   = (rdata >> (8 * k)) & 32'hFF;
        hw  = (rdata >> (16 * h)) & 32'hFFFF;
        mis = 0;
        if (wbsel == 2'd2) wd = pc4;
        else if (wbsel != 2'd1) wd = alu;
        else begin
            case (ldt)
                3'd3: wd = (b >= 32'd128) ? b - 32'd256 : b;
                3'd4: wd = b;
                3'd1: begin wd = (hw >= 32'd32768) ? hw - 32'd65536 : hw; mis = (alu % 2) != 0; end
                3'd2: begin wd = hw; mis = (alu % 2) != 0; end
                default: begin wd = rdata; mis = (alu % 4) != 0; end
            endcase
        end
    endfunction

    task automatic step(input bit v, input bit regwr, input logic [4:0] rd,
                        input logic [1:0] wbsel, input logic [31:0] alu,
                        input logic [31:0] pc4, input logic [31:0] rdata,
                        input logic [2:0] ldt, input bit stall, input bit flush,
                        input bit r);
        logic [31:0] wd;
        bit          mis;
        mif.mem_valid   = v;
        mif.mem_regwr   = regwr;
        mif.mem_rd      = rd;
        mif.mem_wbsel   = wbsel;
        mif.mem_alu_res = alu;
        mif.mem_pc4     = pc4;
        mif.mem_rdata   = rdata;
        mif.mem_ldtype  = ldt;
        mif.wb_stall    = stall;
        mif.wb_flush    = flush;
        rst             = r;
        @(posedge clk);
        if (!r) begin
            cur_v   = 0;
            exp_cnt = 0;
        end else if (flush) begin
            cur_v = 0;
        end else if (!stall) begin
            ref_model(wbsel, alu, pc4, rdata, ldt, wd, mis);
            cur_v  = v && regwr && (rd != 0) && !mis;
            cur_rd = rd;
            cur_wd = wd;
            if (v) begin
                exp_cnt++;
                if (cur_v) wq.push_back('{rd: rd, wd: wd});
                if (mis) mq.push_back(int'(rd));
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 5'd0, 2'd0, 0, 0, 0, 3'd0, 0, 0, 1);
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        step(1, 1, rd, WBSEL_ALU, val, 0, 0, LD_LW, 0, 0, 1);
    endtask

    task automatic chk_cnt(input string nm);
        chk(nm, retire_cnt, exp_cnt % (1 << CNT_W));
    endtask

    // Monitor: pops expected writes / exceptions as the DUT presents them.
    wr_t e;
    int  m;
    always @(negedge clk) begin
        if (mon_en) begin
            if (RFWr === 1'b1) begin
                if (wq.size() == 0) chk("rfwr_unexpected", 1, 0);
                else begin
                    e = wq.pop_front();
                    chk("A3", A3, e.rd);
                    chk("WD", WD, e.wd);
                end
            end else if (RFWr !== 1'b0) chk("rfwr_known", RFWr, 0);
            chk("write_on_time", wq.size(), 0);
            if (exc_misalign === 1'b1) begin
                if (mq.size() == 0) chk("exc_unexpected", 1, 0);
                else begin
                    m = mq.pop_front();
                    chk("exc_rd", fwd_rd, m);
                end
            end else if (exc_misalign !== 1'b0) chk("exc_known", exc_misalign, 0);
            chk("exc_on_time", mq.size(), 0);
            chk("fwd_valid", fwd_valid, cur_v);
            if (cur_v) begin
                chk("fwd_rd", fwd_rd, cur_rd);
                chk("fwd_data", fwd_data, cur_wd);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset
        for (int i = 0; i < 3; i++) step(1, 1, 5'd3, 2'd0, 32'h55, 0, 0, 3'd0, 0, 0, 0);
        chk("rst_RFWr", RFWr, 0);
        chk("rst_A3", A3, 0);
        chk("rst_WD", WD, 0);
        chk("rst_fwd_valid", fwd_valid, 0);
        chk("rst_exc", exc_misalign, 0);
        chk("rst_cnt", retire_cnt, 0);
        mon_en = 1;
        idle(1);

        // Byte loads from the top byte of 0x80FF_1234
        step(1, 1, 5'd5, WBSEL_LOAD, 32'h0000_1003, 0, 32'h80FF_1234, LD_LB, 0, 0, 1);
        step(1, 1, 5'd6, WBSEL_LOAD, 32'h0000_1003, 0, 32'h80FF_1234, LD_LBU, 0, 0, 1);
        idle(1);
        chk("lb_direct", 32'hFFFF_FF80, wq.size() == 0 ? 32'hFFFF_FF80 : 32'h0);
        // Halfword loads: aligned, then misaligned
        step(1, 1, 5'd7, WBSEL_LOAD, 32'h0000_2002, 0, 32'h8001_0000, LD_LH, 0, 0, 1);
        step(1, 1, 5'd8, WBSEL_LOAD, 32'h0000_2001, 0, 32'h8001_0000, LD_LH, 0, 0, 1);
        idle(2);
        chk_cnt("cnt_after_loads");

        // jal to x31, then a write to x0
        step(1, 1, 5'd31, WBSEL_PC4, 32'h1234_5678, 32'h0000_0044, 0, LD_LW, 0, 0, 1);
        step(1, 1, 5'd0, WBSEL_ALU, 32'h0000_0099, 0, 0, LD_LW, 0, 0, 1);
        idle(2);

        // Captured entry held by three stall cycles
        alu_op(5'd9, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++)
            step(1, 1, 5'd12, WBSEL_ALU, 32'h1111_1111, 0, 0, LD_LW, 1, 0, 1);
        idle(2);
        chk_cnt("cnt_after_stall");

        // Flush and stall together on a fresh entry
        step(1, 1, 5'd10, WBSEL_ALU, 32'h0000_0777, 0, 0, LD_LW, 1, 1, 1);
        idle(2);
        chk_cnt("cnt_after_flush");

        // Reset while an entry is held
        alu_op(5'd11, 32'h0BAD_F00D);
        step(0, 0, 5'd0, 2'd0, 0, 0, 0, 3'd0, 1, 0, 1);
        step(0, 0, 5'd0, 2'd0, 0, 0, 0, 3'd0, 1, 0, 0);
        chk("midrst_RFWr", RFWr, 0);
        chk("midrst_A3", A3, 0);
        chk("midrst_WD", WD, 0);
        chk("midrst_fwd_valid", fwd_valid, 0);
        chk("midrst_exc", exc_misalign, 0);
        chk("midrst_cnt", retire_cnt, 0);
        idle(1);

        // Five back-to-back ALU writes
        for (int i = 0; i < 5; i++) alu_op(5'(i + 1), 32'h100 * (i + 1));
        idle(2);
        chk("cnt_five", retire_cnt, 5);

        // Random traffic; several hundred retirements wrap the 8-bit counter
        for (int i = 0; i < 700; i++) begin
            step(($urandom % 5) != 0, ($urandom % 4) != 0,
                 (($urandom % 8) == 0) ? 5'd0 : 5'($urandom % 32),
                 2'($urandom % 4), $urandom, $urandom, $urandom, 3'($urandom % 8),
                 ($urandom % 7) == 0, ($urandom % 12) == 0, 1);
            if (i % 50 == 49) begin
                idle(2);
                chk_cnt("cnt_random");
            end
        end
        idle(2);
        chk_cnt("cnt_final");
        chk("wq_empty", wq.size(), 0);
        chk("mq_empty", mq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
